// File: rtl/seg_disp_pkg.sv
// Shared constants for the multi-digit 7-segment driver: segment patterns,
// the BCD-to-segment table and the conversion FSM states.
package seg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Active-low {a,b,c,d,e,f,g}, indexed by BCD digit value
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/digit_seg_encoder.sv
// Combinational BCD digit to active-low segment pattern, with a blank override.
// Non-decimal nibble codes render as blank.
module digit_seg_encoder
  import seg_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  // Table lookup with blank and out-of-range guards
  always_comb begin
    seg_n_o = SEG_BLANK;
    if (blank_i) begin
      seg_n_o = SEG_BLANK;
    end else if (bcd_i <= 4'd9) begin
      seg_n_o = SEG_TABLE[bcd_i];
    end else begin
      seg_n_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/multi_digit_seg_driver.sv
// Serial double-dabble binary-to-BCD converter feeding a time-multiplexed
// common-bus 7-segment display with leading-zero blanking and overflow dashes.
module multi_digit_seg_driver
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 50000,
  parameter int LZ_BLANK   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n
);

  localparam int BCD_W  = 4 * NUM_DIGITS + 4;
  localparam int DISP_W = 4 * NUM_DIGITS;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic                    busy_s;
  logic [BIN_W-1:0]        bin_q;
  logic [BCD_W-1:0]        bcd_q, bcd_adj_s;
  logic [CNT_W-1:0]        cnt_q;
  logic                    spill_q;
  logic [DISP_W-1:0]       display_q, display_d;
  logic                    overflow_q, overflow_d;
  logic [PRE_W-1:0]        presc_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_DIGITS-1:0]   lz_blank_s, an_s;
  logic [3:0]              digit_s;
  logic                    blank_s;
  logic [6:0]              enc_seg_s;
  logic [6:0]              seg_n_q;
  logic [NUM_DIGITS-1:0]   an_n_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load) state_d = CONV;
        else      state_d = IDLE;
      end
      CONV: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
        else                   state_d = CONV;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_s = 1'b0;
    case (state_q)
      IDLE:    busy_s = 1'b0;
      CONV:    busy_s = 1'b1;
      DONE:    busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Add-3 correction on every nibble ahead of the next shift
  always_comb begin
    bcd_adj_s = bcd_q;
    for (int i = 0; i < NUM_DIGITS + 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // Conversion datapath; spill_q catches bits shifted beyond the guard nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      spill_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            bin_q   <= bin_in;
            bcd_q   <= '0;
            cnt_q   <= '0;
            spill_q <= 1'b0;
          end
        end
        CONV: begin
          bcd_q   <= {bcd_adj_s[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q   <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q   <= cnt_q + CNT_W'(1);
          spill_q <= spill_q | bcd_adj_s[BCD_W-1];
        end
        default: begin
          bin_q <= bin_q;
        end
      endcase
    end
  end

  // Commit result only in DONE so the display never sees a partial value
  always_comb begin
    display_d  = display_q;
    overflow_d = overflow_q;
    if (state_q == DONE) begin
      display_d  = bcd_q[DISP_W-1:0];
      overflow_d = spill_q | (bcd_q[BCD_W-1:DISP_W] != 4'd0);
    end else begin
      display_d  = display_q;
      overflow_d = overflow_q;
    end
  end

  // Display and overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      display_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      display_q  <= display_d;
      overflow_q <= overflow_d;
    end
  end

  // Scan prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRE_LAST) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_LAST) ? IDX_W'(0) : idx_q + IDX_W'(1);
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  // Leading-zero mask, digit mux and anode decode from the upcoming display value
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    lz_blank_s = '0;
    digit_s    = 4'd0;
    blank_s    = 1'b0;
    an_s       = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (display_d[4*i +: 4] == 4'd0);
      lz_blank_s[i] = (LZ_BLANK != 0) && (i != 0) && zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        digit_s = display_d[4*i +: 4];
        blank_s = lz_blank_s[i];
        an_s[i] = 1'b0;
      end else begin
        an_s[i] = 1'b1;
      end
    end
  end

  digit_seg_encoder u_enc (
    .bcd_i   (digit_s),
    .blank_i (blank_s),
    .seg_n_o (enc_seg_s)
  );

  // Segment and anode outputs registered together to avoid ghosting
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_n_q <= SEG_BLANK;
      an_n_q  <= '1;
    end else begin
      seg_n_q <= overflow_d ? SEG_DASH : enc_seg_s;
      an_n_q  <= an_s;
    end
  end

  assign busy     = busy_s;
  assign overflow = overflow_q;
  assign seg_n    = seg_n_q;
  assign an_n     = an_n_q;

endmodule
